// File: rtl/mem_stage.sv
// Memory pipeline stage: word-addressed data RAM with MEM_LATENCY wait states,
// upstream stall, branch redirect, and MEM/WB register. Optional macro: DMEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_WriteReg,
    input  logic        EX_MEM_MemWriteOut,
    input  logic        EX_MEM_MemReadOut,
    input  logic        EX_MEM_MemtoRegOut,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_Branch,
    input  logic [7:0]  EX_MEM_BranchTarget,
    output logic        MemStall,
    output logic        BranchTaken,
    output logic [7:0]  BranchTarget,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_WriteReg,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,
    output logic        MisalignErr
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] LAT_M1 =
        (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_memop, w_stall, w_misalign, w_wr_en;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

    assign w_memop = EX_MEM_MemReadOut | EX_MEM_MemWriteOut;
    assign w_idx   = EX_MEM_ALUResult[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = w_memop & (|EX_MEM_ALUResult[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memop && (MEM_LATENCY != 0)) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = LAT_M1;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset masks the stall so fetch/decode are released in the reset cycle itself.
    assign MemStall     = w_stall & ~rst;
    assign BranchTaken  = EX_MEM_Branch & ~MemStall & ~rst;
    assign BranchTarget = EX_MEM_BranchTarget;

    assign w_wr_en = ~rst & ~w_stall & EX_MEM_MemWriteOut & ~w_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Nonblocking read/write on the same index yields the old word for a load+store.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_idx] <= EX_MEM_WriteData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_WB_ReadData  <= '0;
            MEM_WB_ALUResult <= '0;
            MEM_WB_WriteReg  <= '0;
            MEM_WB_RegWrite  <= 1'b0;
            MEM_WB_MemtoReg  <= 1'b0;
        end else if (w_stall) begin
            MEM_WB_RegWrite  <= 1'b0;
        end else begin
            MEM_WB_ReadData  <= EX_MEM_MemReadOut ? r_mem[w_idx] : 32'h0;
            MEM_WB_ALUResult <= EX_MEM_ALUResult;
            MEM_WB_WriteReg  <= EX_MEM_WriteReg;
            MEM_WB_RegWrite  <= EX_MEM_RegWrite & ~w_misalign;
            MEM_WB_MemtoReg  <= EX_MEM_MemtoRegOut;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_misalign_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign_err <= 1'b0;
        else if (~w_stall && w_misalign)
            r_misalign_err <= 1'b1;
    end

    assign MisalignErr = r_misalign_err;
`else
    assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with zero wait states, one with three.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        mw;
        logic        mr;
        logic        m2r;
        logic        rw;
        logic        br;
        logic [7:0]  bt;
    } ex_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    ex_t  ex0, ex3;

    logic        stall0, bt0, m2r0, rw0, mis0;
    logic [7:0]  btgt0;
    logic [31:0] rd0, alu0;
    logic [4:0]  wr0;
    logic        stall3, bt3, m2r3, rw3, mis3;
    logic [7:0]  btgt3;
    logic [31:0] rd3, alu3;
    logic [4:0]  wr3;

    int errors = 0;
    int checks = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(8), .MEM_LATENCY(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst0),
        .EX_MEM_ALUResult(ex0.alu), .EX_MEM_WriteData(ex0.wd), .EX_MEM_WriteReg(ex0.wr),
        .EX_MEM_MemWriteOut(ex0.mw), .EX_MEM_MemReadOut(ex0.mr), .EX_MEM_MemtoRegOut(ex0.m2r),
        .EX_MEM_RegWrite(ex0.rw), .EX_MEM_Branch(ex0.br), .EX_MEM_BranchTarget(ex0.bt),
        .MemStall(stall0), .BranchTaken(bt0), .BranchTarget(btgt0),
        .MEM_WB_ReadData(rd0), .MEM_WB_ALUResult(alu0), .MEM_WB_WriteReg(wr0),
        .MEM_WB_RegWrite(rw0), .MEM_WB_MemtoReg(m2r0), .MisalignErr(mis0)
    );

    mem_stage #(.ADDR_W(8), .MEM_LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst3),
        .EX_MEM_ALUResult(ex3.alu), .EX_MEM_WriteData(ex3.wd), .EX_MEM_WriteReg(ex3.wr),
        .EX_MEM_MemWriteOut(ex3.mw), .EX_MEM_MemReadOut(ex3.mr), .EX_MEM_MemtoRegOut(ex3.m2r),
        .EX_MEM_RegWrite(ex3.rw), .EX_MEM_Branch(ex3.br), .EX_MEM_BranchTarget(ex3.bt),
        .MemStall(stall3), .BranchTaken(bt3), .BranchTarget(btgt3),
        .MEM_WB_ReadData(rd3), .MEM_WB_ALUResult(alu3), .MEM_WB_WriteReg(wr3),
        .MEM_WB_RegWrite(rw3), .MEM_WB_MemtoReg(m2r3), .MisalignErr(mis3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs; force a load and a branch so masking is exercised.
        rst0 = 1'b1;
        rst3 = 1'b1;
        ex0.alu = $urandom;      ex0.wd = $urandom;      ex0.wr = 5'($urandom);
        ex0.mw  = 1'($urandom);  ex0.mr = 1'b1;          ex0.m2r = 1'($urandom);
        ex0.rw  = 1'b1;          ex0.br = 1'b1;          ex0.bt = 8'($urandom);
        ex3 = ex0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall0", stall0, 0);
        chk("rst_stall3", stall3, 0);
        chk("rst_brtaken0", bt0, 0);
        chk("rst_brtaken3", bt3, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_alu0", alu0, 0);
        chk("rst_wr0", wr0, 0);
        chk("rst_rw0", rw0, 0);
        chk("rst_m2r0", m2r0, 0);
        chk("rst_mis0", mis0, 0);
        chk("rst_rd3", rd3, 0);
        chk("rst_alu3", alu3, 0);
        chk("rst_wr3", wr3, 0);
        chk("rst_rw3", rw3, 0);
        chk("rst_m2r3", m2r3, 0);
        chk("rst_mis3", mis3, 0);
        ex0 = '0;
        ex3 = '0;
        rst0 = 1'b0;
        rst3 = 1'b0;
        tick();

        // Zero-latency store then load.
        ex0 = '0; ex0.mw = 1'b1; ex0.alu = 32'h10; ex0.wd = 32'hDEADBEEF;
        #1 chk("l0_store_stall", stall0, 0);
        tick();
        ex0 = '0; ex0.mr = 1'b1; ex0.alu = 32'h10; ex0.wr = 5'd5; ex0.rw = 1'b1; ex0.m2r = 1'b1;
        #1 chk("l0_load_stall", stall0, 0);
        tick();
        chk("l0_load_rd", rd0, 32'hDEADBEEF);
        chk("l0_load_wr", wr0, 5);
        chk("l0_load_rw", rw0, 1);
        chk("l0_load_m2r", m2r0, 1);

        // Branch resolves combinationally with no register write.
        ex0 = '0; ex0.br = 1'b1; ex0.bt = 8'h2C; ex0.alu = 32'h99;
        #1;
        chk("br_taken", bt0, 1);
        chk("br_target", btgt0, 8'h2C);
        tick();
        chk("br_rw", rw0, 0);
        chk("br_rd", rd0, 0);
        chk("br_alu", alu0, 32'h99);

        // Misaligned store to 0x21 (word 8), after clearing word 8.
        ex0 = '0; ex0.mw = 1'b1; ex0.alu = 32'h20; ex0.wd = 32'h0;
        tick();
        ex0 = '0; ex0.mw = 1'b1; ex0.alu = 32'h21; ex0.wd = 32'hCAFEF00D; ex0.rw = 1'b1; ex0.wr = 5'd3;
        tick();
        chk("mis_rw", rw0, TRAP ? 0 : 1);
        chk("mis_flag", mis0, TRAP ? 1 : 0);
        ex0 = '0; ex0.mr = 1'b1; ex0.alu = 32'h20; ex0.rw = 1'b1; ex0.wr = 5'd4; ex0.m2r = 1'b1;
        tick();
        chk("mis_word8", rd0, TRAP ? 32'h0 : 32'hCAFEF00D);
        chk("mis_sticky", mis0, TRAP ? 1 : 0);
        ex0 = '0;
        tick();
        chk("mis_sticky_idle", mis0, TRAP ? 1 : 0);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("mis_clear", mis0, 0);

        // Three wait states: store, then a load carrying a branch.
        ex3 = '0; ex3.mw = 1'b1; ex3.alu = 32'h10; ex3.wd = 32'hDEADBEEF;
        repeat (3) tick();
        chk("l3_store_last_stall", stall3, 0);
        tick();
        ex3 = '0; ex3.mr = 1'b1; ex3.alu = 32'h10; ex3.rw = 1'b1; ex3.wr = 5'd7; ex3.m2r = 1'b1;
        ex3.br = 1'b1; ex3.bt = 8'h2C;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("l3_stall", stall3, 1);
            chk("l3_br_held", bt3, 0);
            tick();
            chk("l3_bubble_rw", rw3, 0);
        end
        #1;
        chk("l3_commit_stall", stall3, 0);
        chk("l3_commit_br", bt3, 1);
        chk("l3_commit_btgt", btgt3, 8'h2C);
        tick();
        chk("l3_rd", rd3, 32'hDEADBEEF);
        chk("l3_rw", rw3, 1);
        chk("l3_wr", wr3, 7);
        chk("l3_m2r", m2r3, 1);
        chk("l3_alu", alu3, 32'h10);
        ex3 = '0;
        #1 chk("l3_idle_stall", stall3, 0);

        // Store interrupted by reset in the second wait cycle is dropped.
        ex3 = '0; ex3.mw = 1'b1; ex3.alu = 32'h20; ex3.wd = 32'h0;
        repeat (4) tick();
        ex3 = '0; ex3.mw = 1'b1; ex3.alu = 32'h20; ex3.wd = 32'h12345678;
        tick();
        tick();
        chk("rstw_stall_pre", stall3, 1);
        rst3 = 1'b1;
        #1 chk("rstw_stall", stall3, 0);
        tick();
        chk("rstw_rw", rw3, 0);
        rst3 = 1'b0;
        ex3 = '0; ex3.mr = 1'b1; ex3.alu = 32'h20; ex3.rw = 1'b1; ex3.wr = 5'd9;
        #1 chk("rstw_load_stall", stall3, 1);
        repeat (4) tick();
        chk("rstw_rd", rd3, 32'h0);
        chk("rstw_wr", wr3, 9);
        ex3 = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
